// File: rtl/muladd_dot_seq.sv
// muladd_dot_seq
// Sequencer that drives one MULADD DSP BEL (A_reg=0, B_reg=0, C_reg=0,
// ACC=1, ACCout=1) to compute a dot product of start_len operand pairs.
// The BEL accumulator holds the running sum. This block only steers the
// A/B operands and the clr pin, and passes Q straight through as the result.
//
// Ports:
//   UserCLK, reset            clock and synchronous active-high reset
//   start_valid/ready/len     job request handshake and vector length
//   op_valid/ready, op_a/b    streamed operand pairs (accepted only in RUN)
//   res_valid/ready, res_data dot-product result handshake (RESULT state)
//   busy                      high whenever the sequencer is not idle
//   mul_A/B/C, mul_clr        BEL operand and clear pins (C tied to 0)
//   mul_Q                     BEL accumulator output
module muladd_dot_seq #(
    parameter int LEN_W = 8
) (
    input  logic             UserCLK,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [LEN_W-1:0] start_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a,
    input  logic [7:0]       op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [19:0]      res_data,
    output logic             busy,
    output logic [7:0]       mul_A,
    output logic [7:0]       mul_B,
    output logic [19:0]      mul_C,
    output logic             mul_clr,
    input  logic [19:0]      mul_Q
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_RESULT = 2'd2
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             xfer;
    logic             last_xfer;

    // Outputs are gated by reset so the BEL sees clr=1 and zero operands
    // for the whole reset window, regardless of the state before reset.
    always_comb begin
        start_ready = 1'b0;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        mul_clr     = 1'b1;
        if (!reset) begin
            start_ready = (state_q == S_IDLE);
            op_ready    = (state_q == S_RUN);
            res_valid   = (state_q == S_RESULT);
            busy        = (state_q != S_IDLE);
            mul_clr     = (state_q == S_IDLE);
        end
    end

    assign xfer      = op_valid && op_ready;
    // len_q is never 0 in RUN, so len_q-1 cannot underflow here.
    assign last_xfer = xfer && (cnt_q == (len_q - LEN_W'(1)));

    // Zero operands outside a transfer make the product 0, so the
    // accumulator holds during bubbles and in RESULT.
    assign mul_A    = xfer ? op_a : 8'd0;
    assign mul_B    = xfer ? op_b : 8'd0;
    assign mul_C    = 20'd0;
    assign res_data = mul_Q;

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        len_q   <= start_len;
                        cnt_q   <= '0;
                        state_q <= (start_len == '0) ? S_RESULT : S_RUN;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                    if (last_xfer) begin
                        state_q <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muladd_dot_seq.md
Name: muladd_dot_seq

Overview:
- Sequencer that drives one MULADD DSP BEL to compute unsigned or sign-extended dot products of length LEN over a streamed operand-pair interface.
- Sits in user fabric logic beside the DSP tile. It owns the BEL's A, B, C and clr pins, reads Q, and presents start/operand/result valid-ready handshakes to requesters.
- Required static BEL configuration: A_reg=0, B_reg=0, C_reg=0, ACC=1, ACCout=1. signExtension is free; this block is agnostic to it.

Parameters:
- LEN_W, 8, width of the vector-length field; max length is 2^LEN_W-1.

Ports:
- UserCLK  in  1  fabric user clock; all state is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_valid  in  1  job request.
- start_ready  out  1  high only in IDLE.
- start_len  in  LEN_W  number of operand pairs in the job; 0 is legal.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  high only in RUN.
- op_a  in  8  operand A.
- op_b  in  8  operand B.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted.
- res_data  out  20  dot-product result.
- busy  out  1  high when the block is not in IDLE.
- mul_A  out  8  to BEL A.
- mul_B  out  8  to BEL B.
- mul_C  out  20  to BEL C; constant 0.
- mul_clr  out  1  to BEL clr.
- mul_Q  in  20  from BEL Q, which equals the BEL accumulator.

Behaviour:
- Clock is UserCLK; reset is synchronous and active-high.
- Reset: state=IDLE, cnt=0, len_q=0.
  - While reset is high: mul_clr=1, mul_A=mul_B=0, op_ready=0, res_valid=0, busy=0, start_ready=0.
  - The BEL accumulator is therefore cleared at every reset edge.
- States:
  - IDLE:
    - start_ready=1, mul_clr=1, mul_A=mul_B=0.
    - On start_valid: capture start_len into len_q, set cnt=0.
    - If start_len==0, go to RESULT; otherwise go to RUN.
  - RUN:
    - op_ready=1, mul_clr=0.
    - Transfer (op_valid&&op_ready): mul_A=op_a, mul_B=op_b combinationally; the BEL accumulates at that edge; cnt increments.
    - No transfer: mul_A=mul_B=0, so the product is 0 and the accumulator holds.
    - On the transfer where cnt==len_q-1, go to RESULT.
  - RESULT:
    - res_valid=1, res_data=mul_Q (combinational pass-through), mul_clr=0, mul_A=mul_B=0.
    - The accumulator is frozen, so res_data is stable while res_valid is high.
    - On res_ready, go to IDLE.
    - mul_clr reasserts in IDLE, so the accumulator clears on the first IDLE edge.
- Latency:
  - res_valid rises on the cycle after the final operand transfer.
  - A length-0 job asserts res_valid on the cycle after start acceptance, with res_data=0.
  - Minimum job turnaround is LEN+2 cycles: start cycle, LEN transfers, result cycle.
- Arithmetic:
  - Result is the sum of 16-bit products, extended per BEL config, modulo 2^20.
  - Overflow wraps silently; no flag.
- Boundaries:
  - start_valid outside IDLE is ignored; start_ready=0 there.
  - op_valid outside RUN is ignored and never summed.
  - res_ready outside RESULT is ignored.
  - start_len=2^LEN_W-1 must complete without cnt wrap; cnt is LEN_W bits.
  - Reset mid-RUN or mid-RESULT: the job is abandoned, no result is emitted, and the accumulator is cleared. The next job starts clean.
  - Back-to-back jobs: a new start is accepted at the earliest on the cycle after the res_ready handshake, which is in IDLE.
- mul_C is tied to 0. It is unused because the ACC path is selected.

Test Plan:
- Basic job (BEL model: unsigned, ACC=1, ACCout=1): start_len=3; pairs (2,3),(4,5),(10,10) with op_valid held high → res_valid exactly 1 cycle after the 3rd transfer, res_data=126, busy high from start+1 until after the result handshake.
- Bubbles: start_len=4; pairs (1,1),(2,2),(3,3),(4,4) with op_valid low for 2 cycles between each pair → mul_A/mul_B=0 during gaps, res_data=30, exactly 4 transfers counted.
- Zero length: start_len=0 → no op_ready pulse; res_valid on the next cycle with res_data=0.
- Wrap: start_len=17; all pairs (255,255) → res_data=56849 (1105425 mod 2^20).
- Backpressure and back-to-back:
  - Hold res_ready low 5 cycles → res_data stable at its value, start_ready=0, and any op_valid during RESULT is not accepted.
  - Then handshake, and immediately run a second job start_len=1 with (7,6) → res_data=42; no residue from the first job.
- Reset mid-run: start_len=5; after 2 transfers of (9,9), pulse reset for 1 cycle → IDLE, mul_clr=1, no res_valid. A following job start_len=1 with (3,3) gives res_data=9.
